// File: rtl/pid_plant_emulator.sv
// First-order-lag plant emulator for closing a PID loop in hardware: samples the
// actuator drive every SAMPLE_DIV cycles. Optional dead time via `define PLANT_DELAY_EN.
module pid_plant_emulator #(
    parameter int SAMPLE_DIV = 16,
    parameter int LAG_SHIFT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] control,
    input  logic       ctrl_valid,
    input  logic [7:0] disturb,
    output logic [7:0] feedback,
    output logic       fb_valid,
    output logic       sat,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_LATCH   = 3'd2,
        S_UPDATE  = 3'd3,
        S_PUBLISH = 3'd4
    } state_t;

    // WAIT ends early enough that LATCH/UPDATE/PUBLISH plus the return to WAIT
    // make the period exactly SAMPLE_DIV cycles.
    localparam logic [15:0] WAIT_LAST = 16'(SAMPLE_DIV - 4);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] y_q, y_d;
    logic [7:0]  u_hold_q;
    logic [7:0]  u_use_q;
    logic [7:0]  fb_q, fb_d;
    logic        sat_q, sat_d;
    logic [7:0]  u_eff;

    logic signed [16:0] diff_s;
    logic signed [16:0] step_s;
    logic        [15:0] y_next;
    logic signed [9:0]  fb_s;

`ifdef PLANT_DELAY_EN
    logic [3:0][7:0] dly_q;

    // Shifting the previous u_use means dly_q[3] holds the value from four samples ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
        end else if (state_q == S_LATCH) begin
            dly_q <= {dly_q[2:0], u_use_q};
        end
    end

    assign u_eff = dly_q[3];
`else
    assign u_eff = u_use_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == WAIT_LAST) state_d = S_LATCH;
                end
            end
            S_LATCH:  state_d = S_UPDATE;
            S_UPDATE: state_d = S_PUBLISH;
            S_PUBLISH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lag update in Q8.8; the arithmetic shift floors, so a falling output settles exactly.
    assign diff_s = $signed({1'b0, u_eff, 8'h00}) - $signed({1'b0, y_q});
    assign step_s = diff_s >>> LAG_SHIFT;
    assign y_next = 16'($signed({1'b0, y_q}) + step_s);
    assign fb_s   = $signed({2'b00, y_next[15:8]}) + $signed({{2{disturb[7]}}, disturb});

    always_comb begin
        y_d   = y_q;
        fb_d  = fb_q;
        sat_d = sat_q;
        if (state_q == S_UPDATE) begin
            y_d = y_next;
            if (fb_s < 10'sd0) begin
                fb_d  = 8'd0;
                sat_d = 1'b1;
            end else if (fb_s > 10'sd255) begin
                fb_d  = 8'd255;
                sat_d = 1'b1;
            end else begin
                fb_d  = fb_s[7:0];
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            y_q      <= '0;
            u_hold_q <= '0;
            u_use_q  <= '0;
            fb_q     <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            fb_q    <= fb_d;
            sat_q   <= sat_d;
            if (ctrl_valid) u_hold_q <= control;
            // Non-blocking read of u_hold_q: a ctrl_valid in LATCH lands next sample.
            if (state_q == S_LATCH) u_use_q <= u_hold_q;
        end
    end

    assign feedback = fb_q;
    assign sat      = sat_q;
    assign fb_valid = (state_q == S_PUBLISH);
    assign state    = state_q;

endmodule

// File: tb/tb_pid_plant_emulator.sv
// Directed bench for pid_plant_emulator (default parameters); expected values hand-computed.
module tb_pid_plant_emulator;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] control;
    logic       ctrl_valid;
    logic [7:0] disturb;
    logic [7:0] feedback;
    logic       fb_valid;
    logic       sat;
    logic [2:0] state;

    int nchk  = 0;
    int npass = 0;

`ifdef PLANT_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    pid_plant_emulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .control   (control),
        .ctrl_valid(ctrl_valid),
        .disturb   (disturb),
        .feedback  (feedback),
        .fb_valid  (fb_valid),
        .sat       (sat),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; control = 8'd0; ctrl_valid = 1'b0; disturb = 8'd0;
        tick(2);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_fb", 16'(feedback), 16'd0);
        chk("rst_fbv", 16'(fb_valid), 16'd0);
        chk("rst_sat", 16'(sat), 16'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_hold", 16'(state), 16'd0);

        // Step to 255, then enable: E0 is the next edge
        control = 8'd255; ctrl_valid = 1'b1;
        tick(1);
        ctrl_valid = 1'b0; enable = 1'b1;
        tick(1);
        chk("e0_wait", 16'(state), 16'd1);
        tick(13);
        chk("latch_at13", 16'(state), 16'd2);
        tick(1);
        chk("update_at14", 16'(state), 16'd3);
        chk("no_fbv_update", 16'(fb_valid), 16'd0);
        tick(1);
        chk("pub1_fbv", 16'(fb_valid), 16'd1);
        chk("pub1_state", 16'(state), 16'd4);
        chk("pub1_fb", 16'(feedback), DLY ? 16'd0 : 16'd31);
        chk("pub1_sat", 16'(sat), 16'd0);
`ifdef PLANT_DELAY_EN
        repeat (3) begin
            tick(16);
            chk("dly_pub_zero", 16'(feedback), 16'd0);
        end
        tick(16);
        chk("dly_pub5", 16'(feedback), 16'd31);
`endif
        tick(15);
        chk("period_no_fbv", 16'(fb_valid), 16'd0);
        tick(1);
        chk("pub2_fbv", 16'(fb_valid), 16'd1);
        chk("pub2_fb", 16'(feedback), 16'd59);
        chk("pub2_sat", 16'(sat), 16'd0);

`ifndef PLANT_DELAY_EN
        // Falling step with small negative disturbance; new value offered during LATCH waits a sample
        control = 8'd0; ctrl_valid = 1'b1; disturb = 8'hFD;
        tick(1);
        ctrl_valid = 1'b0;
        tick(13);
        chk("p3_latch", 16'(state), 16'd2);
        control = 8'd255; ctrl_valid = 1'b1;
        tick(1);
        ctrl_valid = 1'b0;
        tick(1);
        chk("p3_fbv", 16'(fb_valid), 16'd1);
        chk("p3_fb_fall", 16'(feedback), 16'd49);
        chk("p3_sat", 16'(sat), 16'd0);
        tick(16);
        chk("p4_fb_rise", 16'(feedback), 16'd74);
`endif

        // Settle near full scale, then push past 255
        disturb = 8'd0;
        tick(16 * 50);
        chk("settle_fbv", 16'(fb_valid), 16'd1);
        chk("settle_fb", 16'(feedback), 16'd254);
        chk("settle_sat", 16'(sat), 16'd0);
        disturb = 8'd10;
        tick(16);
        chk("hi_clip_fb", 16'(feedback), 16'd255);
        chk("hi_clip_sat", 16'(sat), 16'd1);

        // Reset to y=0, negative disturbance clips low
        rst_n = 1'b0; control = 8'd0; disturb = 8'hFB;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("lo_e0_wait", 16'(state), 16'd1);
        tick(15);
        chk("lo_fbv", 16'(fb_valid), 16'd1);
        chk("lo_clip_fb", 16'(feedback), 16'd0);
        chk("lo_clip_sat", 16'(sat), 16'd1);

        // Drop enable during UPDATE
        tick(15);
        chk("drop_update", 16'(state), 16'd3);
        enable = 1'b0;
        tick(1);
        chk("drop_pub_state", 16'(state), 16'd4);
        chk("drop_pub_fbv", 16'(fb_valid), 16'd1);
        tick(1);
        chk("drop_wait", 16'(state), 16'd1);
        tick(1);
        chk("drop_idle", 16'(state), 16'd0);
        tick(3);
        chk("idle_stay", 16'(state), 16'd0);
        chk("idle_fbv", 16'(fb_valid), 16'd0);
        chk("idle_sat_hold", 16'(sat), 16'd1);

        // Restart, then reset asserted in LATCH
        disturb = 8'd0; control = 8'd255; ctrl_valid = 1'b1; enable = 1'b1;
        tick(1);
        ctrl_valid = 1'b0;
        chk("re_e0_wait", 16'(state), 16'd1);
        tick(15);
        chk("re_pub_fb", 16'(feedback), DLY ? 16'd0 : 16'd31);
        chk("re_pub_sat", 16'(sat), 16'd0);
        tick(14);
        chk("re_latch", 16'(state), 16'd2);
        rst_n = 1'b0;
        #1;
        chk("async_state", 16'(state), 16'd0);
        chk("async_fb", 16'(feedback), 16'd0);
        chk("async_fbv", 16'(fb_valid), 16'd0);
        chk("async_sat", 16'(sat), 16'd0);
        tick(2);
        chk("rst_hold_fbv", 16'(fb_valid), 16'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_wait", 16'(state), 16'd1);
        tick(15);
        chk("post_rst_fbv", 16'(fb_valid), 16'd1);
        chk("post_rst_fb", 16'(feedback), 16'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
